// File: rtl/ng_key_sched_pkg.sv
// ng_key_pkg: shared constants and types for the keypad input scheduler.
package ng_key_pkg;

  localparam int KEY_W = 5;
  localparam int CNT_W = 5;

  // Requester indices, also used as the round-robin priority value
  localparam logic PAD = 1'b0;
  localparam logic UPL = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } key_state_e;

  // Width of a down-counter that must hold values up to n-1
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ng_key_fifo.sv
// ng_key_fifo: circular key-code buffer with wrapping head/tail pointers and occupancy count.
// A simultaneous push and pop is accepted even when full; the popped slot is the one refilled.
module ng_key_fifo
  import ng_key_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [KEY_W-1:0] push_data_i,
  input  logic             pop_i,
  output logic [KEY_W-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int PTR_W = cnt_width(DEPTH);

  logic [KEY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign pop_data_o = mem_q[head_q];
  assign cnt_o      = cnt_q;

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (do_pop)  head_d = head_q + PTR_W'(1);
    if (do_push) tail_d = tail_q + PTR_W'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
  end

  // Pointer and count registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage write; contents need no reset because the count gates every read
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[tail_q] <= push_data_i;
  end

endmodule

// File: rtl/ng_key_sched.sv
// ng_key_sched: arbitrates keypad and uplink key codes into a FIFO and presents them one at a
// time as KEY_CODE plus a KEY_READY level, retired by KEY_ACK and followed by a fixed low gap.
// Optional build macro KEY_TIMEOUT_EN: retire a key unread after TIMEOUT_CYCLES in ASSERT and
// pulse key_timeout_o; without it the key is held until acked and key_timeout_o is tied low.
module ng_key_sched
  import ng_key_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk2_i,
  input  logic             reset_i,
  input  logic [KEY_W-1:0] pad_code_i,
  input  logic             pad_valid_i,
  output logic             pad_ready_o,
  input  logic [KEY_W-1:0] upl_code_i,
  input  logic             upl_valid_i,
  output logic             upl_ready_o,
  output logic [KEY_W-1:0] key_code_o,
  output logic             key_ready_o,
  input  logic             key_ack_i,
  output logic [CNT_W-1:0] fifo_cnt_o,
  output logic             key_timeout_o
);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ng_key_sched: DEPTH must be a power of two in 2..16");
  end
  if (GAP_CYCLES < 3) begin : g_bad_gap
    $error("ng_key_sched: GAP_CYCLES must be at least 3");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("ng_key_sched: TIMEOUT_CYCLES must be at least 1");
  end

  localparam int               GAP_W    = cnt_width(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  key_state_e       state_q;
  logic [KEY_W-1:0] key_code_q;
  logic             key_ready_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             prio_q;

  logic             grant_upl;
  logic             push, pop;
  logic [KEY_W-1:0] push_data, head_data;
  logic             fifo_full, fifo_empty;

  // Round-robin: UPL wins only when alone or when it holds priority
  assign grant_upl   = upl_valid_i & (~pad_valid_i | (prio_q == UPL));
  assign pad_ready_o = pad_valid_i & ~grant_upl & ~fifo_full;
  assign upl_ready_o = grant_upl & ~fifo_full;
  assign push        = pad_ready_o | upl_ready_o;
  assign push_data   = grant_upl ? upl_code_i : pad_code_i;
  assign pop         = (state_q == IDLE) & ~fifo_empty;

  ng_key_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk2_i),
    .rst_i      (reset_i),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .pop_data_o (head_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .cnt_o      (fifo_cnt_o)
  );

  // Priority passes to the requester that was not just accepted
  always_ff @(posedge clk2_i or posedge reset_i) begin
    if (reset_i)   prio_q <= PAD;
    else if (push) prio_q <= grant_upl ? PAD : UPL;
  end

`ifdef KEY_TIMEOUT_EN
  localparam int              TO_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_q;

  assign key_timeout_o = timeout_q;
`else
  assign key_timeout_o = 1'b0;
`endif

  // Output FSM: present one key, hold it until retired, then keep KEY_READY low for the gap
  always_ff @(posedge clk2_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      key_code_q  <= '0;
      key_ready_q <= 1'b0;
      gap_cnt_q   <= '0;
`ifdef KEY_TIMEOUT_EN
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef KEY_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            key_code_q  <= head_data;
            key_ready_q <= 1'b1;
            state_q     <= ASSERT;
`ifdef KEY_TIMEOUT_EN
            to_cnt_q    <= TO_LOAD;
`endif
          end
        end
        ASSERT: begin
          if (key_ack_i) begin
            key_ready_q <= 1'b0;
            gap_cnt_q   <= GAP_LOAD;
            state_q     <= GAP;
          end
`ifdef KEY_TIMEOUT_EN
          else if (to_cnt_q == '0) begin
            key_ready_q <= 1'b0;
            gap_cnt_q   <= GAP_LOAD;
            timeout_q   <= 1'b1;
            state_q     <= GAP;
          end else begin
            to_cnt_q <= to_cnt_q - TO_W'(1);
          end
`endif
        end
        GAP: begin
          if (gap_cnt_q == '0) state_q   <= IDLE;
          else                 gap_cnt_q <= gap_cnt_q - GAP_W'(1);
        end
        default: begin
          key_ready_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign key_code_o  = key_code_q;
  assign key_ready_o = key_ready_q;

endmodule

// File: tb/tb_ng_key_sched.sv
// tb_ng_key_sched: directed stimulus with a presentation scoreboard for ng_key_sched.
// Build with KEY_TIMEOUT_EN defined to also exercise the unread-key timeout (TIMEOUT_CYCLES=8).
module tb_ng_key_sched;
  import ng_key_pkg::*;

`ifdef KEY_TIMEOUT_EN
  localparam int TO_CYC  = 8;
  localparam int HOLD    = 4;
  localparam int EXP_TOP = 1;
`else
  localparam int TO_CYC  = 65535;
  localparam int HOLD    = 10;
  localparam int EXP_TOP = 0;
`endif
  localparam int DEPTH = 4;
  localparam int GAP   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [KEY_W-1:0] pad_code = '0, upl_code = '0;
  logic             pad_valid = 1'b0, upl_valid = 1'b0, key_ack = 1'b0;
  logic             pad_ready, upl_ready, key_ready, key_timeout;
  logic [KEY_W-1:0] key_code;
  logic [CNT_W-1:0] fifo_cnt;

  int               n_checks = 0;
  int               n_fail = 0;
  int               to_pulses = 0;
  logic [KEY_W-1:0] exp_q[$];
  logic [KEY_W-1:0] mon_exp;
  logic             prev_ready = 1'b0;

  ng_key_sched #(
    .DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk2_i(clk), .reset_i(rst),
    .pad_code_i(pad_code), .pad_valid_i(pad_valid), .pad_ready_o(pad_ready),
    .upl_code_i(upl_code), .upl_valid_i(upl_valid), .upl_ready_o(upl_ready),
    .key_code_o(key_code), .key_ready_o(key_ready), .key_ack_i(key_ack),
    .fifo_cnt_o(fifo_cnt), .key_timeout_o(key_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every KEY_READY rise must present the oldest expected code
  always @(negedge clk) begin
    #2;
    if (key_timeout) to_pulses++;
    if (key_ready && !prev_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_key: code %0d presented, none expected (t=%0t)", key_code, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("key_code", int'(key_code), int'(mon_exp));
      end
    end
    prev_ready = key_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Request one code, wait for acceptance, log it as expected, drop valid after the push edge
  task automatic push_key(input logic upl, input logic [KEY_W-1:0] code);
    int n = 0;
    tick();
    if (upl) begin upl_code = code; upl_valid = 1'b1; end
    else     begin pad_code = code; pad_valid = 1'b1; end
    #1;
    while (!(upl ? upl_ready : pad_ready) && n < 60) begin
      tick(); #1; n++;
    end
    check(upl ? "upl_accept" : "pad_accept", int'(upl ? upl_ready : pad_ready), 1);
    if (upl ? upl_ready : pad_ready) exp_q.push_back(code);
    @(posedge clk); #1;
    pad_valid = 1'b0;
    upl_valid = 1'b0;
  endtask

  // Ack the presented key; with measure set, check edges from retire to next rise
  task automatic ack_key(input bit measure);
    int n = 0;
    tick(); #1;
    while (!key_ready && n < 200) begin
      tick(); #1; n++;
    end
    check("ack_wait_ready", int'(key_ready), 1);
    key_ack = 1'b1;
    @(posedge clk); #1;
    key_ack = 1'b0;
    tick(); #1;
    check("retire_low", int'(key_ready), 0);
    if (measure) begin
      n = 0;
      while (!key_ready && n < 100) begin
        tick(); #1; n++;
      end
      check("gap_edges", n, GAP + 1);
    end
  endtask

  task automatic settle();
    repeat (GAP + 4) tick();
    #1;
  endtask

  initial begin
    int low;
    int n;

    // Reset state
    #2;
    check("rst_key_ready", int'(key_ready), 0);
    check("rst_key_code", int'(key_code), 0);
    check("rst_fifo_cnt", int'(fifo_cnt), 0);
    check("rst_timeout", int'(key_timeout), 0);
    check("rst_pad_ready", int'(pad_ready), 0);
    tick(); rst = 1'b0;

    // Single key
    tick(); pad_code = 5'h13; pad_valid = 1'b1; #1;
    check("t1_pad_ready", int'(pad_ready), 1);
    check("t1_upl_ready", int'(upl_ready), 0);
    exp_q.push_back(5'h13);
    @(posedge clk); #1; pad_valid = 1'b0;
    tick(); #1;
    check("t1_cnt_push", int'(fifo_cnt), 1);
    check("t1_ready_pending", int'(key_ready), 0);
    tick(); #1;
    check("t1_key_ready", int'(key_ready), 1);
    check("t1_cnt_pop", int'(fifo_cnt), 0);
    repeat (HOLD - 1) tick();
    ack_key(1'b0);
    low = 0;
    repeat (GAP - 1) begin tick(); #1; if (!key_ready) low++; end
    check("t1_gap_low", low, GAP - 1);
    check("t1_code_hold", int'(key_code), 'h13);
    check("t1_cnt_end", int'(fifo_cnt), 0);
    settle();

    // Contention from reset: grants alternate starting with PAD
    tick(); rst = 1'b1; pad_code = 5'h01; upl_code = 5'h02; pad_valid = 1'b1; upl_valid = 1'b1;
    tick(); rst = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin tick(); #1; end
      check("cont_pad_grant", int'(pad_ready), (k % 2 == 0) ? 1 : 0);
      check("cont_upl_grant", int'(upl_ready), (k % 2 == 1) ? 1 : 0);
      exp_q.push_back((k % 2 == 0) ? 5'h01 : 5'h02);
    end
    @(posedge clk); #1; pad_valid = 1'b0; upl_valid = 1'b0;
    tick(); #1;
    check("cont_cnt", int'(fifo_cnt), 3);
    repeat (3) ack_key(1'b1);
    ack_key(1'b0);
    settle();
    check("cont_cnt_end", int'(fifo_cnt), 0);
    check("cont_drained", exp_q.size(), 0);

    // Full FIFO
    for (int c = 4; c < 8; c++) push_key(PAD, KEY_W'(c));
    tick(); #1;
    check("full_cnt3", int'(fifo_cnt), 3);
    push_key(PAD, 5'h08);
    tick(); pad_code = 5'h09; pad_valid = 1'b1; #1;
    check("full_cnt4", int'(fifo_cnt), DEPTH);
    check("full_ready_low", int'(pad_ready), 0);
    ack_key(1'b0);
    n = 0;
    while (!pad_ready && n < 60) begin tick(); #1; n++; end
    check("full_reopen_edges", n, GAP + 1);
    if (pad_ready) exp_q.push_back(5'h09);
    @(posedge clk); #1; pad_valid = 1'b0;
    repeat (4) ack_key(1'b1);
    ack_key(1'b0);
    settle();
    check("full_cnt_end", int'(fifo_cnt), 0);

    // Wrap-around: 10 keys, alternating sources
    for (int i = 0; i < 4; i++) push_key(logic'(i % 2), KEY_W'(i));
    for (int i = 4; i < 10; i++) begin
      ack_key(1'b1);
      push_key(logic'(i % 2), KEY_W'(i));
    end
    repeat (3) ack_key(1'b1);
    ack_key(1'b0);
    settle();
    check("wrap_cnt_end", int'(fifo_cnt), 0);
    check("wrap_drained", exp_q.size(), 0);

    // Reset while a key is asserted with two queued
    push_key(PAD, 5'h0A);
    push_key(PAD, 5'h0B);
    push_key(PAD, 5'h0C);
    tick(); #1;
    check("rst_mid_pre_ready", int'(key_ready), 1);
    check("rst_mid_pre_cnt", int'(fifo_cnt), 2);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mid_ready", int'(key_ready), 0);
    check("rst_mid_cnt", int'(fifo_cnt), 0);
    tick(); rst = 1'b0;
    low = 0;
    repeat (10) begin tick(); #1; if (!key_ready) low++; end
    check("rst_mid_quiet", low, 10);
    push_key(UPL, 5'h1F);
    ack_key(1'b0);
    settle();
    check("rst_mid_cnt_end", int'(fifo_cnt), 0);

`ifdef KEY_TIMEOUT_EN
    // Unread key retired after TO_CYC cycles, then gap, then next key
    push_key(PAD, 5'h15);
    push_key(PAD, 5'h16);
    tick(); #1;
    check("to_rise", int'(key_ready), 1);
    n = 0;
    while (!key_timeout && n < 50) begin tick(); #1; n++; end
    check("to_cycles", n, TO_CYC);
    check("to_ready_low", int'(key_ready), 0);
    n = 0;
    while (!key_ready && n < 100) begin tick(); #1; n++; end
    check("to_gap_edges", n, GAP + 1);
    ack_key(1'b0);
    settle();
`endif

    check("timeout_pulses", to_pulses, EXP_TOP);
    check("final_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ng_key_sched.md
# ng_key_sched

Keypad input scheduler for the AGC input port. Arbitrates 5-bit key codes from two requesters, the DSKY keypad scanner and the uplink/host serial path, into a small FIFO. It then presents one code at a time to the input buffer port as a held code plus a Keyready level. Each key is retired on the AGC's channel-read acknowledge and is followed by a guaranteed low gap, so the port's rising-edge detector sees one clean strobe per key.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- GAP_CYCLES, 16: CLK2 cycles KEY_READY is held low after each key; must be ≥ 3.
- TIMEOUT_CYCLES, 65535: ASSERT-state limit; used only when KEY_TIMEOUT_EN is defined.
- CLK2  in  1  AGC main clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- PAD_CODE  in  5  keypad scanner key code.
- PAD_VALID  in  1  keypad request; held until PAD_READY.
- PAD_READY  out  1  keypad code accepted this cycle.
- UPL_CODE  in  5  uplink key code.
- UPL_VALID  in  1  uplink request; held until UPL_READY.
- UPL_READY  out  1  uplink code accepted this cycle.
- KEY_CODE  out  5  code presented to the input port's Keypad field.
- KEY_READY  out  1  drives the input port's Keyready.
- KEY_ACK  in  1  one-cycle pulse when the AGC has read the key channel.
- FIFO_CNT  out  5  current FIFO occupancy, 0..DEPTH.
- KEY_TIMEOUT  out  1  one-cycle pulse when a key is retired unread; tied 0 without KEY_TIMEOUT_EN.

## Operation
- Push arbitration
  - At most one push per cycle.
  - Push allowed only when FIFO_CNT < DEPTH.
  - One requester valid: that requester is granted.
  - Both valid: round-robin. Priority goes to the requester not granted last; after reset, PAD has priority.
  - READY is combinational: valid & granted & not full. A push occurs on the edge where READY=1.
- FIFO: circular buffer with head and tail pointers that wrap modulo DEPTH. A push and a pop in the same cycle leave FIFO_CNT unchanged; this is legal even when the FIFO is full.
- Output FSM has three states:
  - IDLE: KEY_READY=0. If FIFO_CNT>0, pop the head into the KEY_CODE register and go to ASSERT.
  - ASSERT: KEY_READY=1 and KEY_CODE is stable. On KEY_ACK, go to GAP and load the gap counter with GAP_CYCLES-1.
  - GAP: KEY_READY=0. Count down to 0, then go to IDLE.
- KEY_ACK is ignored in IDLE and GAP.
- KEY_CODE holds its last value outside ASSERT.
- Reset value of every output: KEY_READY=0, KEY_CODE=0, FIFO_CNT=0, KEY_TIMEOUT=0. PAD_READY and UPL_READY follow combinationally from the empty FIFO.
- RESET asserted mid-operation empties the FIFO, forces IDLE, clears the round-robin pointer and drops KEY_READY immediately, without waiting for CLK2.

## Timing
- Push latency: a push on edge N gives FIFO_CNT+1 after edge N. In IDLE, KEY_READY=1 with the new code after edge N+1.
- Retire latency: KEY_ACK sampled high on edge M gives KEY_READY=0 after edge M.
- Minimum low time between keys: exactly GAP_CYCLES cycles, then 1 IDLE cycle. The next KEY_READY rises GAP_CYCLES+1 edges after the retire edge.
- Back-to-back push and pop: a push on the same edge as an IDLE pop is visible to the next pop.
- PAD_READY and UPL_READY are never both 1 in the same cycle.

## Configuration
- Macro KEY_TIMEOUT_EN.
- Defined:
  - A counter runs in ASSERT.
  - If TIMEOUT_CYCLES cycles elapse without KEY_ACK, the key is retired: go to GAP, and KEY_TIMEOUT pulses for 1 cycle on that transition.
  - KEY_ACK arriving on the same edge as the timeout counts as an ack; no KEY_TIMEOUT pulse.
- Undefined: ASSERT waits indefinitely. KEY_TIMEOUT is tied 0 and the timeout counter is not built.

## Structure
- Package ng_key_pkg holds:
  - KEY_W = 5
  - the FSM state enum IDLE/ASSERT/GAP
  - the requester index constants PAD = 0, UPL = 1
- Sub-module ng_key_fifo holds the storage, the pointers and FIFO_CNT, with push/pop/full/empty ports.
- Arbitration and the FSM stay in ng_key_sched.

## Test plan
- Single key: PAD_CODE=5'h13 with PAD_VALID for 1 cycle. Expect PAD_READY=1, then KEY_READY=1 with KEY_CODE=13 two edges later. Hold 10 cycles, pulse KEY_ACK. Expect KEY_READY=0 for 16 cycles and FIFO_CNT=0.
- Contention: PAD (5'h01) and UPL (5'h02) both held valid from reset. Expect grants PAD, UPL, PAD, UPL, and presentation order 01, 02, ... after each ack.
- Full FIFO: push 4 codes 5'h04..07 with no ack. Expect FIFO_CNT=3, because the first code is already in ASSERT, then FIFO_CNT=4 with READY=0 on the sixth request. Ack once; expect READY=1 on the next push.
- Wrap-around: 10 keys with acks, sequence 0..9. Expect in-order presentation and FIFO_CNT returning to 0.
- Reset mid-key: assert RESET while in ASSERT with 2 keys queued. Expect KEY_READY=0 immediately and FIFO_CNT=0, and after release nothing presented until a new push.
- KEY_TIMEOUT_EN with TIMEOUT_CYCLES=8: no ack. Expect KEY_TIMEOUT pulse 8 cycles after KEY_READY rise, then GAP, then the next key.
